relu_stream_pipe: RTL and testbench

//  Multi-lane streaming activation unit for the FC datapath: applies a selectable ReLU-family

---
 rtl/relu_stream_pipe.sv | 160 ++++++++++++++++
 tb/tb_relu_stream_pipe.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_stream_pipe.sv
// relu_stream_pipe: multi-lane streaming activation unit (pass / ReLU / leaky / clipped ReLU).
// Two-stage valid/ready pipeline at full throughput. Stage 1 captures the beat and its mode,
// and stage 2 holds the activated result that is presented on out_*.
// Optional feature macro: ACT_STATS_EN adds output-transfer statistics counters
// (stats_clr, stat_beats, stat_zeros).
module relu_stream_pipe #(
  parameter int DATA_W     = 16,
  parameter int LANES      = 4,
  parameter int LEAK_SHIFT = 3,
  parameter int CLIP_VAL   = 1536
`ifdef ACT_STATS_EN
  ,
  parameter int STAT_W     = 32
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [1:0]              in_mode,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    out_last
`ifdef ACT_STATS_EN
  ,
  input  logic                    stats_clr,
  output logic [STAT_W-1:0]       stat_beats,
  output logic [STAT_W-1:0]       stat_zeros
`endif
);

  localparam int unsigned BUS_W = LANES * DATA_W;

  localparam logic [1:0] MODE_PASS  = 2'b00;
  localparam logic [1:0] MODE_RELU  = 2'b01;
  localparam logic [1:0] MODE_LEAKY = 2'b10;
  localparam logic [1:0] MODE_CLIP  = 2'b11;

  localparam logic signed [DATA_W-1:0] ZERO_S = '0;
  localparam logic signed [DATA_W-1:0] CLIP_S = DATA_W'(CLIP_VAL);

  // Stage 1: the raw beat together with its own mode and end-of-vector marker
  logic             s1_valid;
  logic [BUS_W-1:0] s1_data;
  logic [1:0]       s1_mode;
  logic             s1_last;

  // Stage 2: the activated result; it drives the out_* ports directly
  logic             s2_valid;

  // Pipeline advance enables and the activation result for the stage-1 beat
  logic             s1_adv;
  logic             s2_adv;
  logic [BUS_W-1:0] act_data;

  // Activation for one lane. Every result fits in DATA_W bits, including the most-negative input.
  function automatic logic [DATA_W-1:0] act_lane(input logic [DATA_W-1:0] x_raw,
                                                 input logic [1:0]        mode);
    logic signed [DATA_W-1:0] x;
    logic [DATA_W-1:0]        y;
    x = x_raw;
    y = x_raw;
    case (mode)
      MODE_PASS:  y = x_raw;
      MODE_RELU:  if (x <= ZERO_S) y = '0;
      MODE_LEAKY: if (x < ZERO_S) y = x >>> LEAK_SHIFT;
      MODE_CLIP: begin
        if (x <= ZERO_S)      y = '0;
        else if (x >= CLIP_S) y = CLIP_S;
      end
      default:    y = x_raw;
    endcase
    return y;
  endfunction

  // Handshake: a stage may load when it is empty or when the stage after it is draining
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Apply the activation to every lane of the stage-1 beat, using that beat's mode
  always_comb begin
    act_data = '0;
    for (int i = 0; i < LANES; i++) begin
      act_data[i*DATA_W +: DATA_W] = act_lane(s1_data[i*DATA_W +: DATA_W], s1_mode);
    end
  end

  // Stage 1 register: capture an accepted input beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= MODE_PASS;
      s1_last  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_mode <= in_mode;
        s1_last <= in_last;
      end
    end
  end

  // Stage 2 register: hold the result stable while the output is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= act_data;
        out_last <= s1_last;
      end
    end
  end

`ifdef ACT_STATS_EN
  localparam int unsigned CNT_W = $clog2(LANES + 1);

  logic              out_xfer;
  logic [CNT_W-1:0]  zero_cnt;
  logic [STAT_W:0]   beats_sum;
  logic [STAT_W:0]   zeros_sum;

  assign out_xfer  = s2_valid && out_ready;
  assign beats_sum = {1'b0, stat_beats} + (STAT_W + 1)'(1);
  assign zeros_sum = {1'b0, stat_zeros} + (STAT_W + 1)'(zero_cnt);

  // Count the zero-valued lanes of the beat being presented
  always_comb begin
    zero_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      if (out_data[i*DATA_W +: DATA_W] == '0) zero_cnt = zero_cnt + CNT_W'(1);
    end
  end

  // Saturating statistics; a synchronous clear wins over a coincident transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_beats <= '0;
      stat_zeros <= '0;
    end else if (stats_clr) begin
      stat_beats <= '0;
      stat_zeros <= '0;
    end else if (out_xfer) begin
      stat_beats <= beats_sum[STAT_W] ? '1 : beats_sum[STAT_W-1:0];
      stat_zeros <= zeros_sum[STAT_W] ? '1 : zeros_sum[STAT_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_relu_stream_pipe.sv
// tb_relu_stream_pipe: randomized and directed checks of relu_stream_pipe against a
// queue-based behavioural model that uses plain integer arithmetic.
module tb_relu_stream_pipe;

  localparam int DATA_W     = 16;
  localparam int LANES      = 4;
  localparam int LEAK_SHIFT = 3;
  localparam int CLIP_VAL   = 1536;
  localparam int BUS_W      = LANES * DATA_W;
`ifdef ACT_STATS_EN
  localparam int STAT_W     = 32;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [BUS_W-1:0] in_data;
  logic [1:0]       in_mode;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [BUS_W-1:0] out_data;
  logic             out_last;
`ifdef ACT_STATS_EN
  logic              stats_clr;
  logic [STAT_W-1:0] stat_beats;
  logic [STAT_W-1:0] stat_zeros;
`endif

  relu_stream_pipe #(
    .DATA_W(DATA_W), .LANES(LANES), .LEAK_SHIFT(LEAK_SHIFT), .CLIP_VAL(CLIP_VAL)
`ifdef ACT_STATS_EN
    , .STAT_W(STAT_W)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
`ifdef ACT_STATS_EN
    , .stats_clr(stats_clr), .stat_beats(stat_beats), .stat_zeros(stat_zeros)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit rand_ready = 1'b0;

  logic [BUS_W-1:0] exp_data[$];
  logic             exp_last[$];

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void chk_bus(input string name, input logic [BUS_W-1:0] act,
                                  input logic [BUS_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model of one lane: integer arithmetic, floor division for the leaky slope
  function automatic int model_lane(input int x, input int mode);
    int d;
    d = 1 << LEAK_SHIFT;
    case (mode)
      0: return x;
      1: return (x > 0) ? x : 0;
      2: return (x >= 0) ? x : -((-x + d - 1) / d);
      default: return (x <= 0) ? 0 : ((x >= CLIP_VAL) ? CLIP_VAL : x);
    endcase
  endfunction

  function automatic logic [BUS_W-1:0] model_beat(input logic [BUS_W-1:0] d,
                                                  input logic [1:0] m);
    logic [BUS_W-1:0]         r;
    logic signed [DATA_W-1:0] w;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      w = d[i*DATA_W +: DATA_W];
      r[i*DATA_W +: DATA_W] = DATA_W'(model_lane(int'(w), int'(m)));
    end
    return r;
  endfunction

  function automatic int zeros_of(input logic [BUS_W-1:0] d);
    int n;
    n = 0;
    for (int i = 0; i < LANES; i++) if (d[i*DATA_W +: DATA_W] == '0) n++;
    return n;
  endfunction

  function automatic logic [BUS_W-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [BUS_W-1:0] r;
    r = '0;
    r[0*DATA_W +: DATA_W] = DATA_W'(a);
    r[1*DATA_W +: DATA_W] = DATA_W'(b);
    r[2*DATA_W +: DATA_W] = DATA_W'(c);
    r[3*DATA_W +: DATA_W] = DATA_W'(d);
    return r;
  endfunction

  function automatic logic [BUS_W-1:0] rand_bus();
    logic [BUS_W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      case ($urandom_range(0, 7))
        0:       r[i*DATA_W +: DATA_W] = 16'h8000;
        1:       r[i*DATA_W +: DATA_W] = 16'h7FFF;
        2:       r[i*DATA_W +: DATA_W] = 16'h0000;
        3:       r[i*DATA_W +: DATA_W] = 16'hFFFF;
        4:       r[i*DATA_W +: DATA_W] = DATA_W'(CLIP_VAL);
        5:       r[i*DATA_W +: DATA_W] = DATA_W'(CLIP_VAL + 1);
        default: r[i*DATA_W +: DATA_W] = DATA_W'($urandom);
      endcase
    end
    return r;
  endfunction

  // Randomise out_ready on each cycle while enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Scoreboard and monitor, sampled mid-cycle
  logic [BUS_W-1:0] prev_data;
  logic             prev_last;
  bit               stall_prev = 1'b0;
`ifdef ACT_STATS_EN
  longint m_beats = 0;
  longint m_zeros = 0;
  localparam longint STAT_MAX = (64'd1 << STAT_W) - 1;
`endif

  always @(negedge clk) begin
    logic [BUS_W-1:0] ed;
    logic             el;
    if (!rst_n) begin
      exp_data.delete();
      exp_last.delete();
      stall_prev = 1'b0;
`ifdef ACT_STATS_EN
      m_beats = 0;
      m_zeros = 0;
`endif
    end else begin
      ed = '0;
      if (stall_prev) begin
        chk("hold_valid", longint'(out_valid), 1);
        chk_bus("hold_data", out_data, prev_data);
        chk("hold_last", longint'(out_last), longint'(prev_last));
      end
`ifdef ACT_STATS_EN
      chk("stat_beats", longint'(stat_beats), m_beats);
      chk("stat_zeros", longint'(stat_zeros), m_zeros);
`endif
      if (out_valid && out_ready) begin
        if (exp_data.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got out_valid=1 expected no beat (t=%0t)", $time);
        end else begin
          ed = exp_data.pop_front();
          el = exp_last.pop_front();
          chk_bus("out_data", out_data, ed);
          chk("out_last", longint'(out_last), longint'(el));
        end
      end
`ifdef ACT_STATS_EN
      if (stats_clr) begin
        m_beats = 0;
        m_zeros = 0;
      end else if (out_valid && out_ready) begin
        m_beats = (m_beats + 1 > STAT_MAX) ? STAT_MAX : m_beats + 1;
        m_zeros = (m_zeros + zeros_of(ed) > STAT_MAX) ? STAT_MAX : m_zeros + zeros_of(ed);
      end
`endif
      if (in_valid && in_ready) begin
        exp_data.push_back(model_beat(in_data, in_mode));
        exp_last.push_back(in_last);
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // Present a beat until accepted; called and returning just after a rising edge
  task automatic send_beat(input logic [BUS_W-1:0] d, input logic [1:0] m, input logic l);
    bit acc;
    in_data  = d;
    in_mode  = m;
    in_last  = l;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) return;
    end
    chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_data.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", exp_data.size(), 0);
  endtask

  // Single beat with out_ready held high: result must appear exactly two cycles later
  task automatic directed(input string name, input logic [BUS_W-1:0] d, input logic [1:0] m,
                          input logic l, input logic [BUS_W-1:0] exp);
    in_data  = d;
    in_mode  = m;
    in_last  = l;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_early"}, longint'(out_valid), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({name, "_valid"}, longint'(out_valid), 1);
    chk_bus({name, "_data"}, out_data, exp);
    chk({name, "_last"}, longint'(out_last), longint'(l));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    bit got;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 2'b00;
    in_last   = 1'b0;
    out_ready = 1'b0;
`ifdef ACT_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk_bus("rst_out_data", out_data, '0);
    chk("rst_out_last", longint'(out_last), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Pin the model with hand-computed values
    chk("model_leaky_min", model_lane(-32768, 2), -4096);
    chk("model_leaky_m9", model_lane(-9, 2), -2);
    chk("model_clip_hi", model_lane(2000, 3), 1536);

    directed("t1_relu",  pack4(-5, 0, 7, -32768),      2'b01, 1'b0, pack4(0, 0, 7, 0));
    directed("t2_leaky", pack4(-32768, -1, -8, 100),   2'b10, 1'b1, pack4(-4096, -1, -1, 100));
    directed("t2_clip",  pack4(-3, 0, 1536, 2000),     2'b11, 1'b0, pack4(0, 0, 1536, 1536));
    directed("t2_pass",  pack4(-3, 0, 5, 32767),       2'b00, 1'b1, pack4(-3, 0, 5, 32767));

`ifdef ACT_STATS_EN
    stats_clr = 1'b1;
    @(posedge clk);
    #1;
    stats_clr = 1'b0;
    directed("t6_b0", pack4(-5, 0, 7, 9),    2'b01, 1'b0, pack4(0, 0, 7, 9));
    directed("t6_b1", pack4(1, 2, 3, 4),     2'b01, 1'b0, pack4(1, 2, 3, 4));
    directed("t6_b2", pack4(-1, -2, 0, -4),  2'b01, 1'b1, pack4(0, 0, 0, 0));
    @(negedge clk);
    chk("t6_beats", longint'(stat_beats), 3);
    chk("t6_zeros", longint'(stat_zeros), 6);
    @(posedge clk);
    #1;
    in_data  = pack4(-1, 1, -1, 1);
    in_mode  = 2'b01;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    stats_clr = 1'b1;
    @(posedge clk);
    #1;
    stats_clr = 1'b0;
    @(negedge clk);
    chk("t6_clr_beats", longint'(stat_beats), 0);
    chk("t6_clr_zeros", longint'(stat_zeros), 0);
    @(posedge clk);
    #1;
`endif

    // Eight beats alternating ReLU and clipped ReLU, random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_beat(rand_bus(), (i % 2 == 0) ? 2'b01 : 2'b11, 1'((i % 3 == 2) || (i == 7)));
    end
    in_valid = 1'b0;
    drain();

    // Longer random stream with random modes and input gaps
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send_beat(rand_bus(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    in_valid = 1'b0;
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Output stalled for five cycles with input always offered
    out_ready = 1'b0;
    acc       = 0;
    in_data   = rand_bus();
    in_mode   = 2'b10;
    in_last   = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      got = in_ready;
      if (got) acc++;
      @(posedge clk);
      #1;
      if (got) begin
        in_data = rand_bus();
        in_last = 1'b1;
      end
    end
    chk("t4_accepted", acc, 2);
    @(negedge clk);
    chk("t4_in_ready", longint'(in_ready), 0);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_b2b_0", longint'(out_valid), 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t4_b2b_1", longint'(out_valid), 1);
    @(posedge clk);
    #1;
    drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    send_beat(rand_bus(), 2'b01, 1'b1);
    send_beat(rand_bus(), 2'b11, 1'b1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", longint'(out_valid), 0);
    chk_bus("t5_rst_data", out_data, '0);
    chk("t5_rst_last", longint'(out_last), 0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_no_stale", longint'(out_valid), 0);
    end
    chk("t5_in_ready", longint'(in_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
